sram_ctrl: RTL and testbench
============================

# sram_ctrl

Synchronous initiator for the 8K×8 asynchronous SRAM.

- Accepts single-byte read/write requests from on-chip logic over a valid/ready handshake.
- Sequences the SRAM address, strobe and bidirectional data pins with programmable setup/strobe timing.
- Returns read data and a completion pulse.
- Sits between the system bus logic and the SRAM pins; it is the only driver of the SRAM control inputs.

## Interface
- ADDR_W, 13, SRAM address width.
- DATA_W, 8, SRAM data width.
- SETUP_CYC, 1, cycles address/data are stable before the strobe rises (must be ≥1).
- STROBE_CYC, 2, cycles the strobe is held high (must be ≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse for each accepted request.
- rsp_rdata  out  DATA_W  last read data; holds value across writes.
- sram_addr  out  ADDR_W  SRAM address.
- sram_data  inout  DATA_W  SRAM data bus; driven only for writes.
- sram_we  out  1  SRAM write strobe; SRAM captures on its rising edge.
- sram_re  out  1  SRAM read strobe; SRAM drives the bus while high.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD; TURN is present only with the Configuration macro.
- IDLE: req_ready=1. On req_valid&&req_ready, register write/addr/wdata, then go to SETUP.
- SETUP:
  - sram_addr is driven.
  - For writes, sram_data drives the registered wdata.
  - Strobes are low.
  - Lasts SETUP_CYC cycles, then goes to STROBE.
- STROBE: sram_we (write) or sram_re (read) is high for STROBE_CYC cycles. Address and write data are held.
- HOLD: one cycle.
  - Strobes are low; address and write data are held.
  - rsp_valid=1.
  - Next state is IDLE, or TURN after a read when the macro is set.
- Read capture: rsp_rdata is loaded from sram_data on the clock edge that ends the last STROBE cycle.
- sram_data is tri-stated whenever the current access is not a write, and always while sram_re=1. The controller never drives the bus together with sram_re.
- sram_we and sram_re are never high together.
- The cycle counter is $clog2(max(SETUP_CYC,STROBE_CYC))+1 bits wide; it reloads on each state entry.
- Requests arriving while req_ready=0 are ignored. The source must hold them until accepted.
- There is no response backpressure: rsp_valid is a pulse.

## Timing
- Reset values:
  - State IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0.
  - sram_addr=0, sram_we=0, sram_re=0, sram_data=Z.
- Assertion of rst_n low mid-access forces the strobes low and releases the bus immediately (asynchronous); no rsp_valid is produced for the aborted access.
- With the request accepted at edge 0, defaults give:
  - SETUP: cycle 1.
  - STROBE: cycles 2–3.
  - HOLD (rsp_valid): cycle 4.
  - IDLE/ready: cycle 5.
- Request-to-response latency = SETUP_CYC+STROBE_CYC+1 cycles.
- Back-to-back throughput = one access per SETUP_CYC+STROBE_CYC+2 cycles, plus 1 after reads with the macro.

## Configuration
- SRAM_CTRL_TURNAROUND_EN:
  - Defined: after a read, HOLD goes to TURN for one cycle. In TURN, req_ready=0, the bus is tri-stated and the strobes are low; TURN then goes to IDLE. This gives the SRAM time to release the bus.
  - Undefined: HOLD always returns to IDLE; TURN is not built.
- Writes never enter TURN.

## Structure
- Package sram_ctrl_pkg holds:
  - The state enum (IDLE, SETUP, STROBE, HOLD, TURN).
  - Default ADDR_W/DATA_W constants shared with SRAM-side models.
- No sub-module: the counter, FSM and tri-state driver stay in one module.
- Parameter legality (SETUP_CYC≥1, STROBE_CYC≥1) is checked at elaboration.

## Test plan
- Reset, then write 0x5A to 0x0123 with defaults → sram_we high in cycles 2–3 only; sram_data=0x5A from cycle 1 to 4; rsp_valid in cycle 4; req_ready back in cycle 5.
- Read 0x0123 after that write → sram_re high in cycles 2–3; bus never driven by the controller; rsp_rdata=0x5A with rsp_valid in cycle 4.
- SETUP_CYC=3, STROBE_CYC=1: write then read 0x1FFF (top address) → latency 5 cycles each; data 0xA5 round-trips.
- Read immediately followed by a held write request, with and without SRAM_CTRL_TURNAROUND_EN → write accepted 1 cycle later when the macro is set; the controller never drives the bus while sram_re=1.
- rst_n low during STROBE of a write → sram_we drops asynchronously, no rsp_valid, outputs at reset values. A subsequent read works normally.
- req_valid held continuously with alternating read/write → never two strobes high together; exactly one rsp_valid per accepted request.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: FSM state type and default SRAM geometry shared with the controller
// and with SRAM-side models.
`timescale 1ns/1ps
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 13;
  localparam int unsigned SRAM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready initiator for an 8Kx8 asynchronous SRAM with programmable
// setup/strobe timing. Optional macro SRAM_CTRL_TURNAROUND_EN adds a TURN cycle after reads.
`timescale 1ns/1ps
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = SRAM_ADDR_W,
  parameter int unsigned DATA_W     = SRAM_DATA_W,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  logic [DATA_W-1:0] sram_data,
  output logic              sram_we,
  output logic              sram_re
);

  localparam int unsigned CNT_W = $clog2(max_u(SETUP_CYC, STROBE_CYC)) + 1;
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("sram_ctrl: SETUP_CYC must be >= 1");
  end
  if (STROBE_CYC < 1) begin : g_bad_strobe
    $error("sram_ctrl: STROBE_CYC must be >= 1");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy;
  logic                drive_bus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The counter counts down to zero and is reloaded on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = SETUP_LOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LOAD;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          if (!wr_q) begin
            rdata_d = sram_data;
          end
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        cnt_d = '0;
`ifdef SRAM_CTRL_TURNAROUND_EN
        state_d = wr_q ? IDLE : TURN;
`else
        state_d = IDLE;
`endif
      end
`ifdef SRAM_CTRL_TURNAROUND_EN
      TURN: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Strobes and bus enable decode straight from flops, so an asynchronous reset
  // drops them without waiting for a clock edge.
  assign busy      = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
  assign drive_bus = busy && wr_q;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == HOLD);
  assign rsp_rdata = rdata_q;
  assign sram_addr = addr_q;
  assign sram_we   = (state_q == STROBE) && wr_q;
  assign sram_re   = (state_q == STROBE) && !wr_q;
  assign sram_data = drive_bus ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed and randomized checks of sram_ctrl against a cycle-count model
// and an array-based SRAM reference; two instances cover default and SETUP=3/STROBE=1 timing.
`timescale 1ns/1ps
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int S0 = 1;
  localparam int T0 = 2;
  localparam int S1 = 3;
  localparam int T1 = 1;
  localparam int NRAND = 16;
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int TURN_EXTRA = 1;
`else
  localparam int TURN_EXTRA = 0;
`endif

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         req_valid, req_write, req_ready, rsp_valid, sram_we, sram_re;
  logic [1:0][AW-1:0] req_addr, sram_addr;
  logic [1:0][DW-1:0] req_wdata, rsp_rdata;
  wire  [DW-1:0]      bus0, bus1;

  sram_ctrl dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .sram_addr(sram_addr[0]), .sram_data(bus0), .sram_we(sram_we[0]), .sram_re(sram_re[0])
  );

  sram_ctrl #(.SETUP_CYC(S1), .STROBE_CYC(T1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .sram_addr(sram_addr[1]), .sram_data(bus1), .sram_we(sram_we[1]), .sram_re(sram_re[1])
  );

  // Asynchronous SRAM models: drive while read strobe is high, capture on rising write strobe.
  logic [DW-1:0] mem0 [2**AW];
  logic [DW-1:0] mem1 [2**AW];
  assign bus0 = sram_re[0] ? mem0[sram_addr[0]] : 'z;
  assign bus1 = sram_re[1] ? mem1[sram_addr[1]] : 'z;
  always @(posedge sram_we[0]) mem0[sram_addr[0]] <= bus0;
  always @(posedge sram_we[1]) mem1[sram_addr[1]] <= bus1;

  // Reference state: expected memory contents and last read value per instance.
  logic [DW-1:0] model [2][2**AW];
  logic [DW-1:0] last_rd [2];

  int n_cmp = 0;
  int n_bad = 0;

  req_t          q[$];
  req_t          cur, head;
  logic [AW-1:0] wl[$];
  int            accepted, responses, last_acc;
  bit            prev_wr, was_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] bus_of(input int w);
    return (w == 0) ? bus0 : bus1;
  endfunction

  task automatic wait_ready(input int w);
    int n;
    n = 0;
    while (!req_ready[w] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(req_ready[w]), 32'd1);
  endtask

  // One isolated access; checks every cycle from acceptance until ready returns.
  task automatic access(input int w, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int s, t, lat, ready_at;
    logic [3:0] exp_ctl, got_ctl;
    logic [DW-1:0] exp_rd;
    s = (w == 0) ? S0 : S1;
    t = (w == 0) ? T0 : T1;
    lat = s + t + 1;
    ready_at = lat + 1 + (wr ? 0 : TURN_EXTRA);
    exp_rd = wr ? last_rd[w] : model[w][a];
    wait_ready(w);
    req_valid[w] = 1'b1;
    req_write[w] = wr;
    req_addr[w]  = a;
    req_wdata[w] = d;
    for (int k = 1; k <= ready_at; k++) begin
      @(negedge clk);
      if (k == 1) req_valid[w] = 1'b0;
      exp_ctl = {wr && k > s && k <= s + t, !wr && k > s && k <= s + t, k == lat, k == ready_at};
      got_ctl = {sram_we[w], sram_re[w], rsp_valid[w], req_ready[w]};
      chk(wr ? "wr_ctl" : "rd_ctl", 32'(got_ctl), 32'(exp_ctl));
      if (k <= lat) chk("addr", 32'(sram_addr[w]), 32'(a));
      if (wr && k <= lat) chk("wr_bus", 32'(bus_of(w)), 32'(d));
      if (!wr && k > s && k <= s + t) chk("rd_bus", 32'(bus_of(w)), 32'(model[w][a]));
      if (k == lat) chk(wr ? "wr_rdata_hold" : "rd_rdata", 32'(rsp_rdata[w]), 32'(exp_rd));
    end
    if (wr) model[w][a] = d;
    else    last_rd[w] = exp_rd;
  endtask

  task automatic new_rand_req(input int idx);
    if ((idx % 2) == 0) begin
      cur.wr   = 1'b1;
      cur.addr = AW'($urandom_range(0, 2**AW - 1));
      cur.data = DW'($urandom);
      wl.push_back(cur.addr);
    end else begin
      cur.wr   = 1'b0;
      cur.addr = wl[$urandom_range(0, wl.size() - 1)];
      cur.data = DW'($urandom);
    end
    req_valid[0] = 1'b1;
    req_write[0] = cur.wr;
    req_addr[0]  = cur.addr;
    req_wdata[0] = cur.data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_ctl", 32'({sram_we[w], sram_re[w], rsp_valid[w], req_ready[w]}), 32'b0001);
      chk("rst_rdata", 32'(rsp_rdata[w]), 32'd0);
      chk("rst_addr", 32'(sram_addr[w]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Default timing: write then read back.
    access(0, 1'b1, 13'h0123, 8'h5A);
    access(0, 1'b0, 13'h0123, 8'h00);

    // Slow setup / short strobe at the top address.
    access(1, 1'b1, 13'h1FFF, 8'hA5);
    access(1, 1'b0, 13'h1FFF, 8'h00);

    // Reset asserted in the middle of a write strobe.
    wait_ready(0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 13'h0ABC; req_wdata[0] = 8'h3C;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("abort_we_pre", 32'(sram_we[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ctl", 32'({sram_we[0], sram_re[0], rsp_valid[0], req_ready[0]}), 32'b0001);
    chk("abort_rdata", 32'(rsp_rdata[0]), 32'd0);
    chk("abort_addr", 32'(sram_addr[0]), 32'd0);
    model[0][13'h0ABC] = 8'h3C;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'({rsp_valid[0], req_ready[0]}), 32'b01);
    end
    access(0, 1'b0, 13'h0123, 8'h00);
    access(0, 1'b0, 13'h0ABC, 8'h00);

    // Alternating write/read with req_valid held; gaps reveal the turnaround cycle.
    accepted = 0; responses = 0; last_acc = 0; prev_wr = 1'b0;
    new_rand_req(0);
    for (int c = 1; c <= 600 && responses < NRAND; c++) begin
      was_acc = req_valid[0] && req_ready[0];
      @(negedge clk);
      chk("rand_excl", 32'(sram_we[0] & sram_re[0]), 32'd0);
      if ((sram_we[0] || sram_re[0]) && q.size() > 0) begin
        chk("rand_dir", 32'(sram_re[0]), 32'(!q[0].wr));
        if (sram_re[0]) chk("rand_bus", 32'(bus0), 32'(model[0][q[0].addr]));
      end
      if (rsp_valid[0]) begin
        chk("rand_rsp_pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          head = q.pop_front();
          if (head.wr) model[0][head.addr] = head.data;
          else         last_rd[0] = model[0][head.addr];
          chk("rand_rdata", 32'(rsp_rdata[0]), 32'(last_rd[0]));
          responses++;
        end
      end
      if (was_acc) begin
        q.push_back(cur);
        if (accepted > 0)
          chk("rand_gap", 32'(c - last_acc), 32'(S0 + T0 + 2 + (prev_wr ? 0 : TURN_EXTRA)));
        prev_wr = cur.wr;
        last_acc = c;
        accepted++;
        if (accepted < NRAND) new_rand_req(accepted);
        else req_valid[0] = 1'b0;
      end
    end
    chk("rand_responses", 32'(responses), 32'(NRAND));
    chk("rand_accepted", 32'(accepted), 32'(responses));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
